// File: rtl/pe_feed_pkg.sv
// Shared types and default widths/latencies for the PE feed sequencer.
// Imported by the delay line, the interface and the top-level controller.
package pe_feed_pkg;

  localparam int CYCLE_NUM_WIDTH = 9;

  localparam int DEF_ARRAY_SIZE    = 16;
  localparam int DEF_OUTCOME_WIDTH = 32;
  localparam int DEF_ADDR_W_WIDTH  = 10;
  localparam int DEF_ADDR_V_WIDTH  = 10;
  localparam int DEF_ADDR_O_WIDTH  = 8;
  localparam int DEF_SRAM_LAT      = 1;
  localparam int DEF_PE_LAT        = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/pe_feed_ctrl_if.sv
// SRAM/PE-side bus of the feed sequencer. There is no back-pressure: a read issued with ren
// returns data SRAM_LAT cycles later, alu_start marks every cycle that data is valid, and wen_o is a single-cycle write.
interface pe_feed_ctrl_if
  import pe_feed_pkg::*;
#(
  parameter int ARRAY_SIZE    = DEF_ARRAY_SIZE,
  parameter int OUTCOME_WIDTH = DEF_OUTCOME_WIDTH,
  parameter int ADDR_W_WIDTH  = DEF_ADDR_W_WIDTH,
  parameter int ADDR_V_WIDTH  = DEF_ADDR_V_WIDTH,
  parameter int ADDR_O_WIDTH  = DEF_ADDR_O_WIDTH
) ();

  logic                                sram_ren_w;
  logic [ADDR_W_WIDTH-1:0]             sram_raddr_w;
  logic                                sram_ren_v;
  logic [ADDR_V_WIDTH-1:0]             sram_raddr_v;
  logic                                alu_start;
  logic [CYCLE_NUM_WIDTH-1:0]          cycle_num;
  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome;
  logic                                sram_wen_o;
  logic [ADDR_O_WIDTH-1:0]             sram_waddr_o;
  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] sram_wdata_o;

  modport master (
    output sram_ren_w, sram_raddr_w, sram_ren_v, sram_raddr_v,
    output alu_start, cycle_num,
    output sram_wen_o, sram_waddr_o, sram_wdata_o,
    input  mul_outcome
  );

  modport slave (
    input  sram_ren_w, sram_raddr_w, sram_ren_v, sram_raddr_v,
    input  alu_start, cycle_num,
    input  sram_wen_o, sram_waddr_o, sram_wdata_o,
    output mul_outcome
  );

endinterface

// File: rtl/pe_feed_delay.sv
// DEPTH-stage shift register carrying {valid, step} so PE controls line up with SRAM read data.
// drained is high when nothing valid sits behind the output stage (the output holds the last one, if any).
module pe_feed_delay
  import pe_feed_pkg::*;
#(
  parameter int DEPTH = DEF_SRAM_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [CYCLE_NUM_WIDTH-1:0] in_step,
  output logic                       out_valid,
  output logic [CYCLE_NUM_WIDTH-1:0] out_step,
  output logic                       drained
);

  localparam int W = 1 + CYCLE_NUM_WIDTH;

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = {in_valid, in_step};
    for (int s = 1; s < DEPTH; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    drained = !in_valid;
    for (int s = 0; s < DEPTH - 1; s++) begin
      if (stage_q[s][W-1]) drained = 1'b0;
    end
  end

  assign {out_valid, out_step} = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_feed_ctrl.sv
// Tile sequencer ahead of PE_core: issues k_len weight/vector reads, aligns alu_start/cycle_num
// to the read data, waits for the PE result to settle, writes it back and pulses done.
module pe_feed_ctrl
  import pe_feed_pkg::*;
#(
  parameter int ARRAY_SIZE    = DEF_ARRAY_SIZE,
  parameter int OUTCOME_WIDTH = DEF_OUTCOME_WIDTH,
  parameter int ADDR_W_WIDTH  = DEF_ADDR_W_WIDTH,
  parameter int ADDR_V_WIDTH  = DEF_ADDR_V_WIDTH,
  parameter int ADDR_O_WIDTH  = DEF_ADDR_O_WIDTH,
  parameter int SRAM_LAT      = DEF_SRAM_LAT,
  parameter int PE_LAT        = DEF_PE_LAT
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       start,
  input  logic [CYCLE_NUM_WIDTH-1:0] k_len,
  input  logic [ADDR_W_WIDTH-1:0]    w_base,
  input  logic [ADDR_V_WIDTH-1:0]    v_base,
  input  logic [ADDR_O_WIDTH-1:0]    o_addr,
  output logic                       busy,
  output logic                       done,
  output state_e                     dbg_state,
  pe_feed_ctrl_if.master             pe_bus
);

  localparam logic [2:0] PE_CNT_LAST = 3'(PE_LAT - 1);

  state_e                     state_q, state_d;
  logic [CYCLE_NUM_WIDTH-1:0] i_q, i_d;
  logic [2:0]                 pe_cnt_q, pe_cnt_d;
  logic [CYCLE_NUM_WIDTH-1:0] k_len_q, k_len_d;
  logic [ADDR_W_WIDTH-1:0]    w_base_q, w_base_d;
  logic [ADDR_V_WIDTH-1:0]    v_base_q, v_base_d;
  logic [ADDR_O_WIDTH-1:0]    o_addr_q, o_addr_d;

  logic                       fetch;
  logic                       dly_valid;
  logic [CYCLE_NUM_WIDTH-1:0] dly_step;
  logic                       drained;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      pe_cnt_q <= '0;
      k_len_q  <= '0;
      w_base_q <= '0;
      v_base_q <= '0;
      o_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      pe_cnt_q <= pe_cnt_d;
      k_len_q  <= k_len_d;
      w_base_q <= w_base_d;
      v_base_q <= v_base_d;
      o_addr_q <= o_addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    pe_cnt_d = pe_cnt_q;
    k_len_d  = k_len_q;
    w_base_d = w_base_q;
    v_base_d = v_base_q;
    o_addr_d = o_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_len_d  = k_len;
          w_base_d = w_base;
          v_base_d = v_base;
          o_addr_d = o_addr;
          i_d      = '0;
          state_d  = (k_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Compare against k_len-1 so a 9-bit counter covers k_len=511.
        if (i_q == k_len_q - 9'd1) begin
          i_d      = '0;
          pe_cnt_d = '0;
          state_d  = ST_DRAIN;
        end else begin
          i_d = i_q + 9'd1;
        end
      end
      ST_DRAIN: begin
        // Counting starts in the cycle the last aligned step is presented to the PE.
        if (drained) begin
          if (pe_cnt_q == PE_CNT_LAST) state_d = ST_WRITE;
          else                         pe_cnt_d = pe_cnt_q + 3'd1;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign fetch = (state_q == ST_FETCH);

  pe_feed_delay #(
    .DEPTH (SRAM_LAT)
  ) u_delay (
    .clk       (clk),
    .rst       (srst),
    .in_valid  (fetch),
    .in_step   (fetch ? i_q : '0),
    .out_valid (dly_valid),
    .out_step  (dly_step),
    .drained   (drained)
  );

  assign pe_bus.sram_ren_w   = fetch;
  assign pe_bus.sram_raddr_w = fetch ? (w_base_q + ADDR_W_WIDTH'(i_q)) : '0;
  assign pe_bus.sram_ren_v   = fetch;
  assign pe_bus.sram_raddr_v = fetch ? (v_base_q + ADDR_V_WIDTH'(i_q)) : '0;
  assign pe_bus.alu_start    = dly_valid;
  assign pe_bus.cycle_num    = dly_step;
  assign pe_bus.sram_wen_o   = (state_q == ST_WRITE);
  assign pe_bus.sram_waddr_o = (state_q == ST_WRITE) ? o_addr_q : '0;
  assign pe_bus.sram_wdata_o = pe_bus.mul_outcome;

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Bench for pe_feed_ctrl: two instances (SRAM_LAT/PE_LAT = 1/1 and 3/2) share one command stream;
// a per-run cycle schedule is queued at each accepted start and a negedge monitor compares every cycle.
module tb_pe_feed_ctrl;
  import pe_feed_pkg::*;

  localparam int AS   = 16;
  localparam int OW   = 32;
  localparam int AW   = 10;
  localparam int AV   = 10;
  localparam int AO   = 8;
  localparam int SL_A = 1;
  localparam int PL_A = 1;
  localparam int SL_B = 3;
  localparam int PL_B = 2;

  typedef struct packed {
    logic          idle;
    logic          busy;
    logic          done;
    logic          ren_w;
    logic [AW-1:0] raddr_w;
    logic          ren_v;
    logic [AV-1:0] raddr_v;
    logic          alu_start;
    logic [8:0]    cycle_num;
    logic          wen;
    logic [AO-1:0] waddr;
  } snap_t;

  localparam int SNAP_W = $bits(snap_t);
  localparam int REC_W  = 32 + SNAP_W;

  logic clk = 1'b0;
  logic srst = 1'b0;
  logic start = 1'b0;
  logic [8:0] k_len = '0;
  logic [AW-1:0] w_base = '0;
  logic [AV-1:0] v_base = '0;
  logic [AO-1:0] o_addr = '0;
  logic [AS*OW-1:0] mul_val = '0;
  logic busy_a, done_a, busy_b, done_b;
  state_e state_a, state_b;
  int cyc = 0;

  logic [REC_W-1:0] exp_q_a[$];
  logic [REC_W-1:0] exp_q_b[$];
  int free_a = 0;
  int free_b = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic final_req = 1'b0;
  logic final_ack = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_feed_ctrl_if #(.ARRAY_SIZE(AS), .OUTCOME_WIDTH(OW), .ADDR_W_WIDTH(AW),
                    .ADDR_V_WIDTH(AV), .ADDR_O_WIDTH(AO)) bus_a ();
  pe_feed_ctrl_if #(.ARRAY_SIZE(AS), .OUTCOME_WIDTH(OW), .ADDR_W_WIDTH(AW),
                    .ADDR_V_WIDTH(AV), .ADDR_O_WIDTH(AO)) bus_b ();
  assign bus_a.mul_outcome = mul_val;
  assign bus_b.mul_outcome = mul_val;

  pe_feed_ctrl #(.ARRAY_SIZE(AS), .OUTCOME_WIDTH(OW), .ADDR_W_WIDTH(AW), .ADDR_V_WIDTH(AV),
                 .ADDR_O_WIDTH(AO), .SRAM_LAT(SL_A), .PE_LAT(PL_A)) dut_a (
    .clk(clk), .srst(srst), .start(start), .k_len(k_len), .w_base(w_base), .v_base(v_base),
    .o_addr(o_addr), .busy(busy_a), .done(done_a), .dbg_state(state_a), .pe_bus(bus_a));

  pe_feed_ctrl #(.ARRAY_SIZE(AS), .OUTCOME_WIDTH(OW), .ADDR_W_WIDTH(AW), .ADDR_V_WIDTH(AV),
                 .ADDR_O_WIDTH(AO), .SRAM_LAT(SL_B), .PE_LAT(PL_B)) dut_b (
    .clk(clk), .srst(srst), .start(start), .k_len(k_len), .w_base(w_base), .v_base(v_base),
    .o_addr(o_addr), .busy(busy_b), .done(done_b), .dbg_state(state_b), .pe_bus(bus_b));

  snap_t act_a, act_b;
  assign act_a = {state_a == ST_IDLE, busy_a, done_a, bus_a.sram_ren_w, bus_a.sram_raddr_w,
                  bus_a.sram_ren_v, bus_a.sram_raddr_v, bus_a.alu_start, bus_a.cycle_num,
                  bus_a.sram_wen_o, bus_a.sram_waddr_o};
  assign act_b = {state_b == ST_IDLE, busy_b, done_b, bus_b.sram_ren_w, bus_b.sram_raddr_w,
                  bus_b.sram_ren_v, bus_b.sram_raddr_v, bus_b.alu_start, bus_b.cycle_num,
                  bus_b.sram_wen_o, bus_b.sram_waddr_o};

  // ---------------- reference model ----------------
  function automatic int run_len(input int k, input int sl, input int pl);
    return (k == 0) ? 1 : k + sl + pl + 1;
  endfunction

  // Expected outputs c cycles after the accepting cycle (c = 1 .. run_len).
  function automatic snap_t model_snap(input int c, input int k, input logic [AW-1:0] w,
                                       input logic [AV-1:0] v, input logic [AO-1:0] o,
                                       input int sl, input int pl);
    snap_t s;
    s = '0;
    s.busy = 1'b1;
    s.done = (c == run_len(k, sl, pl));
    if (c >= 1 && c <= k) begin
      s.ren_w   = 1'b1;
      s.raddr_w = AW'(int'(w) + c - 1);
      s.ren_v   = 1'b1;
      s.raddr_v = AV'(int'(v) + c - 1);
    end
    if (c >= sl + 1 && c <= sl + k) begin
      s.alu_start = 1'b1;
      s.cycle_num = 9'(c - 1 - sl);
    end
    if (k > 0 && c == k + sl + pl) begin
      s.wen   = 1'b1;
      s.waddr = o;
    end
    return s;
  endfunction

  task automatic model_accept(input int t, input int k, input logic [AW-1:0] w,
                              input logic [AV-1:0] v, input logic [AO-1:0] o);
    int len;
    if (t >= free_a) begin
      len = run_len(k, SL_A, PL_A);
      for (int c = 1; c <= len; c++)
        exp_q_a.push_back({32'(t + c), model_snap(c, k, w, v, o, SL_A, PL_A)});
      free_a = t + len + 1;
    end
    if (t >= free_b) begin
      len = run_len(k, SL_B, PL_B);
      for (int c = 1; c <= len; c++)
        exp_q_b.push_back({32'(t + c), model_snap(c, k, w, v, o, SL_B, PL_B)});
      free_b = t + len + 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    for (int l = 0; l < AS; l++) mul_val[l*OW +: OW] = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input int k, input logic [AW-1:0] w, input logic [AV-1:0] v,
                       input logic [AO-1:0] o);
    start  = 1'b1;
    k_len  = 9'(k);
    w_base = w;
    v_base = v;
    o_addr = o;
    model_accept(cyc, k, w, v, o);
    step();
    start  = 1'b0;
    k_len  = 9'($urandom);
    w_base = AW'($urandom);
    v_base = AV'($urandom);
    o_addr = AO'($urandom);
  endtask

  task automatic wait_free();
    while (cyc < free_a || cyc < free_b) step();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    snap_t exp_s;
    logic [REC_W-1:0] rec;
    if (srst) begin
      exp_q_a.delete();
      exp_q_b.delete();
      n_checks++;
      if (act_a !== snap_t'(SNAP_W'(1) << (SNAP_W - 1))) begin
        n_errors++;
        $display("FAIL reset_a cyc=%0d act=%h exp=%h", cyc, act_a, snap_t'(SNAP_W'(1) << (SNAP_W - 1)));
      end
      n_checks++;
      if (act_b !== snap_t'(SNAP_W'(1) << (SNAP_W - 1))) begin
        n_errors++;
        $display("FAIL reset_b cyc=%0d act=%h exp=%h", cyc, act_b, snap_t'(SNAP_W'(1) << (SNAP_W - 1)));
      end
    end else begin
      exp_s = '0;
      exp_s.idle = 1'b1;
      if (exp_q_a.size() > 0 && exp_q_a[0][REC_W-1 -: 32] == 32'(cyc)) begin
        rec = exp_q_a.pop_front();
        exp_s = rec[SNAP_W-1:0];
      end
      n_checks++;
      if (act_a !== exp_s) begin
        n_errors++;
        $display("FAIL snap_a cyc=%0d act=%h exp=%h", cyc, act_a, exp_s);
      end
      if (exp_s.wen) begin
        n_checks++;
        if (bus_a.sram_wdata_o !== mul_val) begin
          n_errors++;
          $display("FAIL wdata_a cyc=%0d act=%h exp=%h", cyc, bus_a.sram_wdata_o[63:0], mul_val[63:0]);
        end
      end

      exp_s = '0;
      exp_s.idle = 1'b1;
      if (exp_q_b.size() > 0 && exp_q_b[0][REC_W-1 -: 32] == 32'(cyc)) begin
        rec = exp_q_b.pop_front();
        exp_s = rec[SNAP_W-1:0];
      end
      n_checks++;
      if (act_b !== exp_s) begin
        n_errors++;
        $display("FAIL snap_b cyc=%0d act=%h exp=%h", cyc, act_b, exp_s);
      end
      if (exp_s.wen) begin
        n_checks++;
        if (bus_b.sram_wdata_o !== mul_val) begin
          n_errors++;
          $display("FAIL wdata_b cyc=%0d act=%h exp=%h", cyc, bus_b.sram_wdata_o[63:0], mul_val[63:0]);
        end
      end
    end
    if (final_req && !final_ack) begin
      n_checks++;
      if (exp_q_a.size() != 0) begin
        n_errors++;
        $display("FAIL leftover_a act=%0d entries exp=0", exp_q_a.size());
      end
      n_checks++;
      if (exp_q_b.size() != 0) begin
        n_errors++;
        $display("FAIL leftover_b act=%0d entries exp=0", exp_q_b.size());
      end
      final_ack = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int gap;
    #1 srst = 1'b1;
    idle(3);
    srst = 1'b0;
    idle(2);

    // Basic run, then an ignored start mid-run, one in the done cycle, and a re-accept at done+1.
    issue(5, 10'h010, 10'h020, 8'h07);
    idle(2);
    issue(5, 10'h100, 10'h200, 8'h55);
    idle(4);
    issue(5, 10'h120, 10'h220, 8'h66);
    issue(3, 10'h030, 10'h040, 8'h09);
    wait_free();
    idle(1);

    // Address wrap and k_len=0.
    issue(4, 10'h3FE, 10'h3FF, 8'h12);
    wait_free();
    issue(0, 10'h111, 10'h222, 8'h33);
    wait_free();
    issue(2, 10'h005, 10'h006, 8'h44);
    wait_free();

    // Reset during FETCH step 2, then a fresh run.
    issue(5, 10'h010, 10'h020, 8'h07);
    idle(1);
    #1 srst = 1'b1;
    step();
    srst = 1'b0;
    free_a = 0;
    free_b = 0;
    idle(1);
    issue(3, 10'h010, 10'h020, 8'h07);
    wait_free();

    // Randomized runs, sometimes back-to-back so overlapping starts get ignored.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       k = 0;
        1:       k = 1;
        2:       k = $urandom_range(20, 40);
        default: k = $urandom_range(2, 8);
      endcase
      issue(k, AW'($urandom), AV'($urandom), AO'($urandom));
      gap = $urandom_range(0, 3);
      idle(gap);
      if ($urandom_range(0, 2) != 0) wait_free();
    end
    wait_free();

    issue(511, 10'h3F0, 10'h001, 8'hFF);
    wait_free();
    idle(3);

    final_req = 1'b1;
    repeat (4) begin
      if (!final_ack) step();
    end
    if (!final_ack) begin
      n_errors++;
      $display("FAIL final_check act=no_ack exp=ack");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_feed_ctrl.md
Name: pe_feed_ctrl

Overview:
Sequencer directly upstream of PE_core that runs one matrix-vector tile.
- Issues weight-column and vector-element SRAM reads.
- Drives PE_core's alu_start/cycle_num aligned to the SRAM read data.
- Waits for the PE accumulation to settle, writes the 16-lane mul_outcome into the output SRAM, and pulses done.
- The SRAM read data buses go straight from SRAM to PE_core; this block carries control and addresses only, plus the outcome write-back.

Parameters:
ARRAY_SIZE, 16, PE lanes per tile
OUTCOME_WIDTH, 32, bits per lane result (fp32)
ADDR_W_WIDTH, 10, weight SRAM address width
ADDR_V_WIDTH, 10, vector SRAM address width
ADDR_O_WIDTH, 8, output SRAM address width
SRAM_LAT, 1, read latency in cycles from ren/addr to rdata (1..4)
PE_LAT, 1, cycles from the last alu_start-high cycle to mul_outcome final (1..4)

Ports:
clk  in  1  clock, rising edge
srst  in  1  asynchronous active-high reset
start  in  1  single-cycle request; accepted only in IDLE
k_len  in  9  number of accumulation steps (0..511), sampled with start
w_base  in  ADDR_W_WIDTH  first weight column address, sampled with start
v_base  in  ADDR_V_WIDTH  first vector element address, sampled with start
o_addr  in  ADDR_O_WIDTH  output row address, sampled with start
busy  out  1  high from the cycle after accept through the done cycle
done  out  1  one-cycle completion pulse
sram_ren_w  out  1  weight SRAM read enable
sram_raddr_w  out  ADDR_W_WIDTH  weight read address
sram_ren_v  out  1  vector SRAM read enable
sram_raddr_v  out  ADDR_V_WIDTH  vector read address
alu_start  out  1  to PE_core; high in every cycle whose SRAM data is valid
cycle_num  out  9  to PE_core; step index of the data currently presented
mul_outcome  in  ARRAY_SIZE*OUTCOME_WIDTH  from PE_core
sram_wen_o  out  1  output SRAM write enable
sram_waddr_o  out  ADDR_O_WIDTH  output write address
sram_wdata_o  out  ARRAY_SIZE*OUTCOME_WIDTH  write data; combinational copy of mul_outcome

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0; the alignment delay line is flushed; latched k_len, bases and o_addr are cleared.
- States:
  - IDLE: start=1 → latch inputs. If k_len=0 go to DONE, otherwise go to FETCH. start=0 stays IDLE.
  - FETCH: lasts k_len cycles with step i=0..k_len-1. ren_w=ren_v=1, raddr_w=w_base+i, raddr_v=v_base+i. Addresses wrap modulo 2^width. The last step goes to DRAIN.
  - DRAIN: wait until the delay line is empty, then PE_LAT further cycles. Then go to WRITE.
  - WRITE: one cycle with sram_wen_o=1 and sram_waddr_o=latched o_addr; then go to DONE.
  - DONE: one cycle with done=1; then go to IDLE.
- Alignment: alu_start and cycle_num are the FETCH-issue valid bit and step index delayed by exactly SRAM_LAT cycles. With start sampled in cycle T, alu_start is high for cycles T+1+SRAM_LAT .. T+k_len+SRAM_LAT, with cycle_num=0..k_len-1.
- Outside valid cycles cycle_num=0 and alu_start=0.
- The WRITE cycle is the last alu_start cycle + PE_LAT.
- sram_wen_o is 0 in every state except WRITE. sram_waddr_o is 0 outside WRITE.
- start while busy or in DONE: ignored with no side effects. The earliest re-accept is the cycle after done.
- k_len=0: done at T+1; no reads, no alu_start, no write.
- Counter i is 9 bits; compare against k_len-1, so there is no overflow at k_len=511.

Decomposition:
- Package pe_feed_pkg holds:
  - state enum: IDLE, FETCH, DRAIN, WRITE, DONE
  - CYCLE_NUM_WIDTH=9
  - default widths and latencies
- Sub-module pe_feed_delay: parameterised DEPTH × (1+9)-bit shift register with async reset. Carries {valid, step} for SRAM_LAT alignment and its empty flag.

Test Plan:
- SRAM_LAT=1, PE_LAT=1, k_len=5, w_base=0x010, v_base=0x020, o_addr=0x07, start at T:
  - raddr_w 0x010..0x014 and raddr_v 0x020..0x024 on T+1..T+5
  - alu_start on T+2..T+6 with cycle_num 0..4
  - wen_o at T+7, addr 0x07, wdata=mul_outcome (expect 16 lanes of weight×15.0 with the PE_core model and weights 1.0..8.0)
  - done at T+8; busy T+1..T+8
- Wrap: w_base=0x3FE, v_base=0x3FF, k_len=4 → raddr_w 0x3FE,0x3FF,0x000,0x001; raddr_v 0x3FF,0x000,0x001,0x002.
- k_len=0 → done at T+1, busy high only at T+1, no ren/alu_start/wen.
- start pulsed at T+3 and in the done cycle of a k_len=5 run → both ignored (no address change). start at done+1 → accepted.
- srst asserted mid-FETCH (step 2) → all outputs 0 in the same cycle. After release, a fresh k_len=3 run reproduces the exact timing of the first scenario scaled to k_len=3.
- SRAM_LAT=3, PE_LAT=2, k_len=2 → alu_start on T+4..T+5, wen_o at T+7, done at T+8.
